// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 4-stage pipeline front end.
package pipeline_pkg;

  localparam int INSTR_W_DEF = 8;
  localparam int PC_W_DEF    = 8;

  // Top two bits of each instruction select the operation in the control unit.
  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b11;

  // Fetch FSM encoding, also visible on the debug port of fetch_stage.
  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} buffer that catches a fetch response arriving
// while decode is stalled and the IF/ID register is still occupied.
module fetch_skid_buf
  import pipeline_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;

  // Clear (redirect) wins over load, load wins over unload.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
//
// Memory handshake: a request is accepted in the cycle where imem_req and
// imem_gnt are both high; at most one request is outstanding, and its
// response is the first imem_rvalid seen while in WAIT. rvalid outside WAIT
// is ignored. Decode handshake: ifid_valid marks a live instruction and
// id_stall=1 means decode did not take it, so the register must hold.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [1:0]         ifid_opcode,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] ST_REQ  = F_REQ;
  localparam logic [1:0] ST_WAIT = F_WAIT;
  localparam logic [1:0] ST_HOLD = F_HOLD;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               drop_q, drop_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;

  logic               skid_load, skid_unload, skid_clear;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               slot_free;

  fetch_skid_buf #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .instr_i  (imem_rdata),
    .pc_i     (fetch_pc_q),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  // IF/ID can take new data if empty or decode consumes the current entry.
  assign slot_free = !ifid_valid_q || !id_stall;

  // Next-state logic: redirect overrides everything, including id_stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    drop_d       = drop_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      ifid_valid_d = 1'b0;
      skid_clear   = 1'b1;
      // A response still in flight must be swallowed before refetching.
      if (state_q == ST_WAIT && !imem_rvalid) begin
        state_d = ST_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = ST_REQ;
        drop_d  = 1'b0;
      end
    end else begin
      if (slot_free) ifid_valid_d = 1'b0;
      case (state_q)
        ST_REQ: begin
          if (imem_gnt) begin
            state_d    = ST_WAIT;
            fetch_pc_d = pc_q;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else if (slot_free) begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_rdata;
              ifid_pc_d    = fetch_pc_q;
              pc_d         = pc_q + PC_W'(1);
              state_d      = ST_REQ;
            end else begin
              skid_load = 1'b1;
              pc_d      = pc_q + PC_W'(1);
              state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!id_stall) begin
            ifid_valid_d = skid_valid;
            ifid_instr_d = skid_instr;
            ifid_pc_d    = skid_pc;
            skid_unload  = 1'b1;
            state_d      = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // State registers with synchronous reset; reset also abandons any response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      drop_q       <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_q       <= drop_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_opcode = ifid_instr_q[INSTR_W-1 -: 2];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the memory handshake is driven cycle by
// cycle from one initial block and every output is checked against
// hand-computed values.
module tb_fetch_stage;
  import pipeline_pkg::*;

  logic       clk;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_gnt;
  logic       imem_rvalid;
  logic [7:0] imem_rdata;
  logic       id_stall;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       ifid_valid;
  logic [7:0] ifid_instr;
  logic [7:0] ifid_pc;
  logic [1:0] ifid_opcode;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(
    .INSTR_W  (8),
    .PC_W     (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_opcode    (ifid_opcode),
    .dbg_state      (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [7:0] ins,
                            input logic [7:0] pc, input logic [1:0] op);
    check({tag, ".valid"}, 32'(ifid_valid), 32'(v));
    if (v) begin
      check({tag, ".instr"},  32'(ifid_instr),  32'(ins));
      check({tag, ".pc"},     32'(ifid_pc),     32'(pc));
      check({tag, ".opcode"}, 32'(ifid_opcode), 32'(op));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, 32'(ifid_valid), 32'h0);
    check({tag, ".instr"}, 32'(ifid_instr), 32'h0);
    check({tag, ".pc"},    32'(ifid_pc),    32'h0);
    check({tag, ".req"},   32'(imem_req),   32'h1);
    check({tag, ".addr"},  32'(imem_addr),  32'h0);
    check({tag, ".state"}, 32'(dbg_state),  32'(F_REQ));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One zero-wait fetch: grant now, response on the following cycle.
  task automatic fetch_one(input logic [7:0] data);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 8'h00;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;

    // Reset values
    do_reset();
    check_reset_state("rst");

    // Zero-wait stream: 05, 47, C3 with a bubble between each
    fetch_one(8'h05);
    check_ifid("seq0", 1'b1, 8'h05, 8'h00, 2'b00);
    check("seq0.addr", 32'(imem_addr), 32'h01);
    tick();
    check("seq0.bubble", 32'(ifid_valid), 32'h0);
    fetch_one(8'h47);
    check_ifid("seq1", 1'b1, 8'h47, 8'h01, 2'b01);
    imem_gnt = 1'b1;
    tick();
    check("seq1.req_in_wait", 32'(imem_req), 32'h0);
    check("seq1.bubble", 32'(ifid_valid), 32'h0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 8'hC3;
    tick();
    imem_rvalid = 1'b0;
    check_ifid("seq2", 1'b1, 8'hC3, 8'h02, 2'b11);

    // Stall while IF/ID holds 05: next response lands in the skid
    do_reset();
    fetch_one(8'h05);
    check_ifid("stall0", 1'b1, 8'h05, 8'h00, 2'b00);
    id_stall = 1'b1;
    fetch_one(8'h47);
    check_ifid("stall.hold", 1'b1, 8'h05, 8'h00, 2'b00);
    check("stall.state", 32'(dbg_state), 32'(F_HOLD));
    check("stall.req", 32'(imem_req), 32'h0);
    check("stall.addr", 32'(imem_addr), 32'h02);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("stall.req2", 32'(imem_req), 32'h0);
    check_ifid("stall.hold2", 1'b1, 8'h05, 8'h00, 2'b00);
    id_stall = 1'b0;
    tick();
    check_ifid("stall.release", 1'b1, 8'h47, 8'h01, 2'b01);
    check("stall.rel_state", 32'(dbg_state), 32'(F_REQ));
    check("stall.rel_addr", 32'(imem_addr), 32'h02);

    // Redirect while waiting: late response is discarded
    imem_gnt = 1'b1;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h20;
    tick();
    redirect_valid = 1'b0;
    check("redir.state", 32'(dbg_state), 32'(F_WAIT));
    check("redir.addr", 32'(imem_addr), 32'h20);
    check("redir.valid", 32'(ifid_valid), 32'h0);
    tick();
    check("redir.still_wait", 32'(dbg_state), 32'(F_WAIT));
    imem_rvalid = 1'b1;
    imem_rdata  = 8'hAA;
    tick();
    imem_rvalid = 1'b0;
    check("redir.drop_valid", 32'(ifid_valid), 32'h0);
    check("redir.drop_state", 32'(dbg_state), 32'(F_REQ));
    check("redir.drop_addr", 32'(imem_addr), 32'h20);
    fetch_one(8'h3C);
    check_ifid("redir.target", 1'b1, 8'h3C, 8'h20, 2'b00);
    check("redir.next_addr", 32'(imem_addr), 32'h21);

    // Redirect coinciding with rvalid while decode is stalled
    id_stall = 1'b1;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check_ifid("rv_redir.held", 1'b1, 8'h3C, 8'h20, 2'b00);
    imem_rvalid    = 1'b1;
    imem_rdata     = 8'h99;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    tick();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    check("rv_redir.valid", 32'(ifid_valid), 32'h0);
    check("rv_redir.state", 32'(dbg_state), 32'(F_REQ));
    check("rv_redir.addr", 32'(imem_addr), 32'h40);
    id_stall = 1'b0;

    // PC wrap from FF to 00
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap.addr_ff", 32'(imem_addr), 32'hFF);
    fetch_one(8'h81);
    check_ifid("wrap.ifid", 1'b1, 8'h81, 8'hFF, 2'b10);
    check("wrap.addr_00", 32'(imem_addr), 32'h00);

    // Reset while waiting
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("rst_wait.pre", 32'(dbg_state), 32'(F_WAIT));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_wait");

    // Reset while holding a skid entry
    fetch_one(8'h11);
    id_stall = 1'b1;
    fetch_one(8'h22);
    check("rst_hold.pre", 32'(dbg_state), 32'(F_HOLD));
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    id_stall = 1'b0;
    check_reset_state("rst_hold");
    tick();
    check("rst_hold.no_skid", 32'(ifid_valid), 32'h0);
    fetch_one(8'h33);
    check_ifid("rst_hold.refetch", 1'b1, 8'h33, 8'h00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
